// File: rtl/monolith_pkg.sv
// rtl/monolith_pkg.sv - Mersenne-31 constants, circulant row and FSM type for the Monolith-31 layers
package monolith_pkg;

    localparam int DEF_WORD_WIDTH = 31;
    localparam int DEF_STATE_SIZE = 16;
    localparam int COEF_WIDTH     = 7;
    localparam int ACC_WIDTH      = 31 + COEF_WIDTH + 5;

    localparam logic [30:0] P = 31'h7FFFFFFF;

    // First row of the 16x16 circulant MDS matrix of Monolith-31
    localparam logic [COEF_WIDTH-1:0] CIRC_ROW [16] = '{
        7'd1,   7'd1,  7'd51, 7'd1,  7'd11, 7'd17, 7'd2,  7'd1,
        7'd101, 7'd63, 7'd15, 7'd2,  7'd67, 7'd22, 7'd13, 7'd3
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } concrete_state_e;

    // The coefficient is a constant at every call site, so this collapses to a few shifted adds
    function automatic logic [ACC_WIDTH-1:0] mul_const(input logic [30:0] x,
                                                       input logic [COEF_WIDTH-1:0] c);
        logic [ACC_WIDTH-1:0] r;
        r = '0;
        for (int b = 0; b < COEF_WIDTH; b++) begin
            if (c[b]) r = r + (ACC_WIDTH'(x) << b);
        end
        return r;
    endfunction

endpackage

// File: rtl/m31_fold_reduce.sv
// rtl/m31_fold_reduce.sv - combinational reduction of a wide accumulator to canonical Mersenne-31
module m31_fold_reduce
    import monolith_pkg::*;
#(
    parameter int ACC_W = ACC_WIDTH
) (
    input  logic [ACC_W-1:0] acc,
    output logic [30:0]      value
);

    logic [31:0] fold1;
    logic [31:0] fold2;
    logic [31:0] diff;

    // 2^31 == 1 mod p, so the high bits can be added back onto the low 31 bits
    always_comb begin
        fold1 = {1'b0, acc[30:0]} + 32'(acc[ACC_W-1:31]);
        fold2 = {1'b0, fold1[30:0]} + {31'b0, fold1[31]};
        diff  = fold2 - {1'b0, P};
        value = (fold2 >= {1'b0, P}) ? diff[30:0] : fold2[30:0];
    end

endmodule

// File: rtl/monolith_concrete.sv
// rtl/monolith_concrete.sv - iterative Concrete layer: one circulant row of M*x + rc per cycle
module monolith_concrete
    import monolith_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int STATE_SIZE = DEF_STATE_SIZE
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] state_in,
    input  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] round_const,
    input  logic                                  input_valid,
    output logic                                  input_ready,
    output logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] state_out,
    output logic                                  output_valid,
    input  logic                                  output_ready
);

    localparam int ROW_W = $clog2(STATE_SIZE);

    concrete_state_e                        state_q, state_d;
    logic [ROW_W-1:0]                       row_q, row_d;
    logic [STATE_SIZE-1:0][WORD_WIDTH-1:0]  x_q, x_d;
    logic [STATE_SIZE-1:0][WORD_WIDTH-1:0]  rc_q, rc_d;
    logic [STATE_SIZE-1:0][WORD_WIDTH-1:0]  result_q, result_d;
    logic [ACC_WIDTH-1:0]                   acc;
    logic [30:0]                            row_value;

    // x_q and rc_q rotate by one word per row, so coefficient k always meets x[(k+row) mod 16]
    always_comb begin
        acc = ACC_WIDTH'(rc_q[0]);
        for (int k = 0; k < STATE_SIZE; k++) begin
            acc = acc + mul_const(x_q[k], CIRC_ROW[k]);
        end
    end

    m31_fold_reduce #(.ACC_W(ACC_WIDTH)) u_fold (
        .acc   (acc),
        .value (row_value)
    );

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        x_d          = x_q;
        rc_d         = rc_q;
        result_d     = result_q;
        input_ready  = 1'b0;
        output_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                input_ready = 1'b1;
                if (input_valid) begin
                    x_d     = state_in;
                    rc_d    = round_const;
                    row_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                result_d[row_q] = row_value;
                row_d           = row_q + 1'b1;
                for (int k = 0; k < STATE_SIZE; k++) begin
                    x_d[k]  = x_q[(k + 1) % STATE_SIZE];
                    rc_d[k] = rc_q[(k + 1) % STATE_SIZE];
                end
                if (row_q == ROW_W'(STATE_SIZE - 1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                output_valid = 1'b1;
                if (output_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            row_q    <= '0;
            x_q      <= '0;
            rc_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            x_q      <= x_d;
            rc_q     <= rc_d;
            result_q <= result_d;
        end
    end

    assign state_out = result_q;

endmodule
